pwm_capture: RTL and testbench
==============================

// Module: pwm_capture
// PURPOSE
// - Receive-side counterpart of the SoC PWM output: measures period and high time of an external
//   pulse train on one pin, in io_mainClk cycles.
// - Sits beside the Murax peripherals; a bus bridge pops results via a valid/ready handshake.
// - Detects a stuck pin (0%/100% duty, no signal) and lost results.
// PARAMETERS
// - CNT_WIDTH    24  width of the cycle counter and of both measurement outputs
// - SYNC_STAGES  2   flops in the input synchronizer (>=2)
// - FILTER_LEN   4   stable-sample count of the glitch filter; used only with PWM_CAPTURE_FILTER_EN
// PORTS
// - io_mainClk      in   1          system clock; all logic on rising edge
// - io_asyncResetn  in   1          asynchronous active-low reset
// - io_enable       in   1          1 = capture running; 0 = return to IDLE, clear flags
// - io_pwm_pin      in   1          asynchronous PWM input
// - io_level        out  1          synchronized (filtered) pin level
// - io_meas_valid   out  1          measurement available
// - io_meas_ready   in   1          consumer accepts measurement when valid&ready
// - io_meas_period  out  CNT_WIDTH  cycles rising edge to next rising edge
// - io_meas_high    out  CNT_WIDTH  cycles rising edge to falling edge
// - io_overrun      out  1          sticky: a completed measurement was dropped
// - io_timeout      out  1          one-cycle pulse: counter saturated without a rising edge
// BEHAVIOUR
// - Reset: all outputs 0, state IDLE, counter 0, synchronizer flops 0.
// - Pin passes SYNC_STAGES flops -> lvl; rise = lvl&~lvl_q, fall = ~lvl&lvl_q (lvl_q = lvl delayed 1).
// - States: IDLE, ARM, HIGH, LOW.
//   IDLE: io_enable=1 -> ARM. ARM: rise -> HIGH, cnt<=1 (first rising edge never produces a result).
//   HIGH: fall -> LOW, high_r<=cnt. LOW: rise -> HIGH, cnt<=1, result completes (period=cnt, high=high_r).
//   Otherwise in HIGH/LOW cnt<=cnt+1. Pin high H cycles, low L cycles -> period=H+L, high=H.
// - Saturation: cnt reaching all-ones in HIGH or LOW -> io_timeout=1 one cycle, state ARM, cnt<=0;
//   no result produced.
// - io_enable=0 in any state -> IDLE next cycle; cnt, io_meas_valid, io_overrun cleared; a held
//   measurement is discarded.
// - Output latency: io_meas_valid rises the cycle after the completing rise; pin-to-lvl is SYNC_STAGES.
// - Handshake: period/high held stable while valid&~ready; valid&ready -> valid drops next cycle
//   unless a new result completes that same cycle (then new values load, valid stays 1, no overrun).
// - Result completes while valid&~ready: new result dropped, held values kept, io_overrun<=1
//   (sticky until io_enable=0 or reset).
// - Consumer may hold io_meas_ready=1 permanently; then every result shows valid exactly 1 cycle.
// - Fall and rise never coincide on one cycle (single lvl); a rise seen in HIGH (missed fall,
//   impossible by construction) is treated as an error-free restart: cnt<=1, no result.
// CONFIGURATION
// - PWM_CAPTURE_FILTER_EN defined: lvl changes only after the synchronized pin has held the new value
//   for FILTER_LEN consecutive cycles; pulses shorter than FILTER_LEN are ignored; pin-to-lvl latency
//   becomes SYNC_STAGES+FILTER_LEN; measured values unchanged for clean inputs (both edges equally delayed).
// - Not defined: lvl is the raw synchronizer output; no filter logic is built.
// TESTING
// - Enable, pin 30 high/70 low, ready=1 -> from 2nd rise each result period=100, high=30, valid 1-cycle pulses.
// - ready=0, two full periods of 40/60 -> first result (100,40) held, io_overrun=1, values unchanged;
//   then ready=1 -> one transfer, valid drops.
// - ready pulsed on the exact cycle a new result completes -> new values load, valid stays 1, io_overrun=0.
// - CNT_WIDTH=8, pin held high -> io_timeout pulse 255 cycles after the counted rise, state ARM, no valid.
// - io_enable dropped mid-HIGH with valid pending -> valid=0, overrun=0 next cycle; re-enable: first rise
//   reports nothing, next rise reports correct period.
// - PWM_CAPTURE_FILTER_EN, FILTER_LEN=4, 2-cycle glitches on a 50/50 period-100 signal -> results (100,50);
//   without the macro, same stimulus -> glitch-distorted results.

Source files
------------

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time of an external pulse train in io_mainClk cycles.
// Optional glitch filter on the synchronized pin is built when PWM_CAPTURE_FILTER_EN is defined.
module pwm_capture #(
  parameter int CNT_WIDTH   = 24,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic                 io_mainClk,
  input  logic                 io_asyncResetn,
  input  logic                 io_enable,
  input  logic                 io_pwm_pin,
  output logic                 io_level,
  output logic                 io_meas_valid,
  input  logic                 io_meas_ready,
  output logic [CNT_WIDTH-1:0] io_meas_period,
  output logic [CNT_WIDTH-1:0] io_meas_high,
  output logic                 io_overrun,
  output logic                 io_timeout,
  output logic [1:0]           io_dbg_state
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_HIGH = 2'd2;
  localparam logic [1:0] ST_LOW  = 2'd3;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   sync_out;
  logic                   lvl;
  logic                   lvl_q;
  logic                   rise;
  logic                   fall;
  logic [1:0]             state;
  logic [CNT_WIDTH-1:0]   cnt;
  logic [CNT_WIDTH-1:0]   high_r;
  logic                   counting;
  logic                   sat;
  logic                   done;

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], io_pwm_pin};
    end
  end

  assign sync_out = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
  // The level follows the synchronizer only after FILTER_LEN identical samples in a row,
  // so both edges are delayed equally and clean pulse widths are preserved.
  localparam int FLT_W = $clog2(FILTER_LEN + 1);

  logic [FLT_W-1:0] flt_cnt;
  logic             flt_lvl;

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      flt_cnt <= '0;
      flt_lvl <= 1'b0;
    end else if (sync_out == flt_lvl) begin
      flt_cnt <= '0;
    end else if (flt_cnt == FLT_W'(FILTER_LEN - 1)) begin
      flt_lvl <= sync_out;
      flt_cnt <= '0;
    end else begin
      flt_cnt <= flt_cnt + FLT_W'(1);
    end
  end

  assign lvl = flt_lvl;
`else
  assign lvl = sync_out;

  // FILTER_LEN only sizes the optional glitch filter.
  if (FILTER_LEN < 1) begin : g_filter_len_unused
  end
`endif

  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      lvl_q <= 1'b0;
    end else begin
      lvl_q <= lvl;
    end
  end

  // A single level signal cannot rise and fall in the same cycle.
  assign rise = lvl & ~lvl_q;
  assign fall = ~lvl & lvl_q;

  assign counting = (state == ST_HIGH) || (state == ST_LOW);
  assign sat      = counting && (cnt == CNT_MAX);
  assign done     = (state == ST_LOW) && rise && !sat;

  // Saturation wins over any edge seen in the same cycle: the measurement is abandoned.
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      high_r <= '0;
    end else if (!io_enable) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          state <= ST_ARM;
          cnt   <= '0;
        end
        ST_ARM: begin
          if (rise) begin
            state <= ST_HIGH;
            cnt   <= CNT_ONE;
          end
        end
        ST_HIGH: begin
          if (sat) begin
            state <= ST_ARM;
            cnt   <= '0;
          end else if (rise) begin
            // Missed fall: restart the period from this edge without reporting.
            cnt <= CNT_ONE;
          end else begin
            if (fall) begin
              state  <= ST_LOW;
              high_r <= cnt;
            end
            cnt <= cnt + CNT_ONE;
          end
        end
        ST_LOW: begin
          if (sat) begin
            state <= ST_ARM;
            cnt   <= '0;
          end else if (rise) begin
            state <= ST_HIGH;
            cnt   <= CNT_ONE;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= ST_IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  // Handshake: a result transfers on any cycle with io_meas_valid & io_meas_ready. While
  // valid is high and ready low, period/high are frozen. A result completing in a transfer
  // cycle loads directly and keeps valid high; one completing while the held result is
  // still stalled is dropped and latches io_overrun until disable or reset.
  always_ff @(posedge io_mainClk or negedge io_asyncResetn) begin
    if (!io_asyncResetn) begin
      io_meas_valid  <= 1'b0;
      io_meas_period <= '0;
      io_meas_high   <= '0;
      io_overrun     <= 1'b0;
    end else if (!io_enable) begin
      io_meas_valid <= 1'b0;
      io_overrun    <= 1'b0;
    end else if (done) begin
      if (!io_meas_valid || io_meas_ready) begin
        io_meas_valid  <= 1'b1;
        io_meas_period <= cnt;
        io_meas_high   <= high_r;
      end else begin
        io_overrun <= 1'b1;
      end
    end else if (io_meas_ready) begin
      io_meas_valid <= 1'b0;
    end
  end

  assign io_timeout   = io_enable && sat;
  assign io_level     = lvl;
  assign io_dbg_state = state;

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: pin waveforms are planned as level segments, and a
// segment-level model derives the expected (period, high) stream for the scoreboard.
module tb_pwm_capture;

  localparam int CNT_WIDTH   = 24;
  localparam int SYNC_STAGES = 2;
  localparam int FILTER_LEN  = 4;
`ifdef PWM_CAPTURE_FILTER_EN
  localparam int FLT_LAT   = FILTER_LEN;
  localparam bit FILTER_ON = 1'b1;
`else
  localparam int FLT_LAT   = 0;
  localparam bit FILTER_ON = 1'b0;
`endif
  localparam int LAT = SYNC_STAGES + FLT_LAT;
  localparam int RW  = 2 * CNT_WIDTH;

  // clock / reset / stimulus signals
  logic                 clk    = 1'b0;
  logic                 rst_n  = 1'b0;
  logic                 enable = 1'b0;
  logic                 pin    = 1'b0;
  logic                 ready  = 1'b0;
  logic                 level;
  logic                 meas_valid;
  logic [CNT_WIDTH-1:0] meas_period;
  logic [CNT_WIDTH-1:0] meas_high;
  logic                 overrun;
  logic                 timeout;
  logic [1:0]           dbg_state;

  logic                 en8  = 1'b0;
  logic                 pin8 = 1'b0;
  logic                 level8;
  logic                 meas_valid8;
  logic [7:0]           meas_period8;
  logic [7:0]           meas_high8;
  logic                 overrun8;
  logic                 timeout8;
  logic [1:0]           dbg_state8;

  int checks = 0;
  int errors = 0;

  logic [RW-1:0] exp_q[$];
  int            plan_lvl[$];
  int            plan_len[$];
  bit            mon_en = 1'b0;
  logic [RW-1:0] mon_v;

  always #5 clk = ~clk;

  pwm_capture #(.CNT_WIDTH(CNT_WIDTH), .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_dut (
    .io_mainClk     (clk),
    .io_asyncResetn (rst_n),
    .io_enable      (enable),
    .io_pwm_pin     (pin),
    .io_level       (level),
    .io_meas_valid  (meas_valid),
    .io_meas_ready  (ready),
    .io_meas_period (meas_period),
    .io_meas_high   (meas_high),
    .io_overrun     (overrun),
    .io_timeout     (timeout),
    .io_dbg_state   (dbg_state)
  );

  pwm_capture #(.CNT_WIDTH(8), .SYNC_STAGES(SYNC_STAGES), .FILTER_LEN(FILTER_LEN)) u_dut8 (
    .io_mainClk     (clk),
    .io_asyncResetn (rst_n),
    .io_enable      (en8),
    .io_pwm_pin     (pin8),
    .io_level       (level8),
    .io_meas_valid  (meas_valid8),
    .io_meas_ready  (ready),
    .io_meas_period (meas_period8),
    .io_meas_high   (meas_high8),
    .io_overrun     (overrun8),
    .io_timeout     (timeout8),
    .io_dbg_state   (dbg_state8)
  );

  // scoreboard: every accepted transfer pops one expected result
  always @(negedge clk) begin
    if (mon_en && meas_valid && ready) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_extra: got period=%0d high=%0d, expected no result", meas_period, meas_high);
      end else begin
        mon_v = exp_q.pop_front();
        if ({meas_period, meas_high} !== mon_v) begin
          errors++;
          $display("FAIL scoreboard_result: got period=%0d high=%0d, expected period=%0d high=%0d",
                   meas_period, meas_high, mon_v[RW-1:CNT_WIDTH], mon_v[CNT_WIDTH-1:0]);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic plan_clear();
    plan_lvl.delete();
    plan_len.delete();
    exp_q.delete();
  endtask

  task automatic plan_add(input int v, input int n);
    plan_lvl.push_back(v);
    plan_len.push_back(n);
  endtask

  // Reference: merge segments the filter would swallow, then report each rise-to-rise interval.
  task automatic model_compute();
    int lv[$];
    int ln[$];
    int t;
    int rise_t;
    int fall_t;
    bit have_rise;
    logic [CNT_WIDTH-1:0] p;
    logic [CNT_WIDTH-1:0] h;
    for (int i = 0; i < plan_lvl.size(); i++) begin
      if (lv.size() > 0 && (lv[lv.size()-1] == plan_lvl[i] || (FILTER_ON && plan_len[i] < FILTER_LEN)))
        ln[ln.size()-1] += plan_len[i];
      else begin
        lv.push_back(plan_lvl[i]);
        ln.push_back(plan_len[i]);
      end
    end
    t = 0; rise_t = 0; fall_t = 0; have_rise = 1'b0;
    for (int i = 0; i < lv.size(); i++) begin
      if (i > 0 && lv[i] == 1) begin
        if (have_rise) begin
          p = CNT_WIDTH'(t - rise_t);
          h = CNT_WIDTH'(fall_t - rise_t);
          exp_q.push_back({p, h});
        end
        rise_t = t;
        have_rise = 1'b1;
      end else if (i > 0) begin
        fall_t = t;
      end
      t += ln[i];
    end
  endtask

  task automatic drive_plan(input int n_segs);
    for (int i = 0; i < n_segs; i++) begin
      pin = (plan_lvl[i] != 0);
      tick(plan_len[i]);
    end
  endtask

  task automatic run_plan();
    model_compute();
    ready  = 1'b1;
    mon_en = 1'b1;
    enable = 1'b1;
    drive_plan(plan_lvl.size());
    tick(LAT + 6);
    mon_en = 1'b0;
  endtask

  task automatic finish_plan(input string name);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_missing: got %0d results left unreported, expected 0", name, exp_q.size());
    end
    enable = 1'b0;
    pin    = 1'b0;
    tick(4);
    exp_q.delete();
  endtask

  // tests
  task automatic test_reset();
    rst_n = 1'b0;
    pin   = 1'b1;
    tick(3);
    checks++; if (level !== 1'b0) begin errors++; $display("FAIL reset_level: got %b, expected 0", level); end
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", meas_valid); end
    checks++; if (meas_period !== '0 || meas_high !== '0) begin errors++; $display("FAIL reset_meas: got %0d/%0d, expected 0/0", meas_period, meas_high); end
    checks++; if (overrun !== 1'b0 || timeout !== 1'b0) begin errors++; $display("FAIL reset_flags: got overrun=%b timeout=%b, expected 0/0", overrun, timeout); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d, expected 0", dbg_state); end
    pin = 1'b0;
    rst_n = 1'b1;
    tick(SYNC_STAGES + FLT_LAT + 3);
    checks++; if (dbg_state !== 2'd0 || dbg_state8 !== 2'd0) begin errors++; $display("FAIL idle_state: got %0d/%0d, expected 0/0", dbg_state, dbg_state8); end
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b, expected 0", meas_valid); end
  endtask

  task automatic test_steady();
    plan_clear();
    plan_add(0, 8);
    for (int k = 0; k < 5; k++) begin plan_add(1, 30); plan_add(0, 70); end
    plan_add(1, 30);
    plan_add(0, 20);
    run_plan();
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL steady_overrun: got %b, expected 0", overrun); end
    finish_plan("steady");
  endtask

  task automatic test_random();
    plan_clear();
    plan_add(0, 8);
    for (int k = 0; k < 8; k++) begin
      plan_add(1, int'($urandom_range(150, 5)));
      plan_add(0, int'($urandom_range(150, 5)));
    end
    plan_add(1, 20);
    plan_add(0, 20);
    run_plan();
    finish_plan("random");
  endtask

  task automatic test_overrun();
    logic [RW-1:0] held;
    plan_clear();
    plan_add(0, 8);
    plan_add(1, 40); plan_add(0, 60);
    plan_add(1, 40); plan_add(0, 60);
    plan_add(1, 20); plan_add(0, 10);
    model_compute();
    held   = exp_q[0];
    ready  = 1'b0;
    enable = 1'b1;
    drive_plan(plan_lvl.size());
    tick(LAT + 3);
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid: got %b, expected 1", meas_valid); end
    checks++; if ({meas_period, meas_high} !== held) begin errors++; $display("FAIL overrun_held: got %0d/%0d, expected %0d/%0d", meas_period, meas_high, held[RW-1:CNT_WIDTH], held[CNT_WIDTH-1:0]); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag: got %b, expected 1", overrun); end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL overrun_drain: got valid=%b, expected 0", meas_valid); end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b, expected 1", overrun); end
    enable = 1'b0;
    tick(1);
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear: got %b, expected 0", overrun); end
    tick(3);
    exp_q.delete();
  endtask

  task automatic test_back_to_back();
    plan_clear();
    plan_add(0, 8);
    plan_add(1, 40); plan_add(0, 60);
    plan_add(1, 25); plan_add(0, 55);
    plan_add(1, 30);
    model_compute();
    ready  = 1'b0;
    enable = 1'b1;
    drive_plan(plan_lvl.size() - 1);
    checks++; if (meas_valid !== 1'b1 || {meas_period, meas_high} !== exp_q[0]) begin errors++; $display("FAIL b2b_first: got valid=%b %0d/%0d, expected 1 %0d/%0d", meas_valid, meas_period, meas_high, exp_q[0][RW-1:CNT_WIDTH], exp_q[0][CNT_WIDTH-1:0]); end
    pin = 1'b1;
    tick(LAT);
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    checks++; if (meas_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid: got %b, expected 1", meas_valid); end
    checks++; if (meas_period !== exp_q[1][RW-1:CNT_WIDTH]) begin errors++; $display("FAIL b2b_period: got %0d, expected %0d", meas_period, exp_q[1][RW-1:CNT_WIDTH]); end
    checks++; if (meas_high !== exp_q[1][CNT_WIDTH-1:0]) begin errors++; $display("FAIL b2b_high: got %0d, expected %0d", meas_high, exp_q[1][CNT_WIDTH-1:0]); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun: got %b, expected 0", overrun); end
    ready = 1'b1;
    tick(1);
    ready = 1'b0;
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got valid=%b, expected 0", meas_valid); end
    enable = 1'b0;
    pin    = 1'b0;
    tick(4);
    exp_q.delete();
  endtask

  task automatic test_enable_drop();
    plan_clear();
    plan_add(0, 8);
    for (int k = 0; k < 3; k++) begin plan_add(1, 40); plan_add(0, 60); end
    ready  = 1'b0;
    enable = 1'b1;
    drive_plan(plan_lvl.size());
    pin = 1'b1;
    tick(LAT + 10);
    checks++; if (meas_valid !== 1'b1 || overrun !== 1'b1) begin errors++; $display("FAIL drop_pre: got valid=%b overrun=%b, expected 1/1", meas_valid, overrun); end
    enable = 1'b0;
    tick(1);
    checks++; if (meas_valid !== 1'b0) begin errors++; $display("FAIL drop_valid: got %b, expected 0", meas_valid); end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL drop_overrun: got %b, expected 0", overrun); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL drop_state: got %0d, expected 0", dbg_state); end
    pin = 1'b0;
    tick(LAT + 8);
    plan_clear();
    plan_add(0, 8);
    plan_add(1, 35); plan_add(0, 65);
    plan_add(1, 35); plan_add(0, 20);
    run_plan();
    finish_plan("reenable");
  endtask

  task automatic test_timeout();
    int first_n = -1;
    int pulses  = 0;
    int state_after = -1;
    bit saw_valid = 1'b0;
    en8  = 1'b1;
    pin8 = 1'b0;
    tick(8);
    pin8 = 1'b1;
    for (int n = 0; n < LAT + 300; n++) begin
      @(negedge clk);
      if (timeout8) begin
        pulses++;
        if (first_n < 0) first_n = n;
      end
      if (first_n >= 0 && n == first_n + 1) state_after = int'(dbg_state8);
      if (meas_valid8) saw_valid = 1'b1;
    end
    checks++; if (first_n != LAT + 255) begin errors++; $display("FAIL timeout_latency: got cycle %0d, expected %0d", first_n, LAT + 255); end
    checks++; if (pulses != 1) begin errors++; $display("FAIL timeout_width: got %0d cycles, expected 1", pulses); end
    checks++; if (state_after != 1) begin errors++; $display("FAIL timeout_state: got %0d, expected 1", state_after); end
    checks++; if (saw_valid) begin errors++; $display("FAIL timeout_valid: got valid=1, expected 0"); end
    #1;
    en8  = 1'b0;
    pin8 = 1'b0;
    tick(2);
  endtask

  task automatic test_glitch();
    plan_clear();
    plan_add(0, 8);
    for (int k = 0; k < 4; k++) begin
      plan_add(1, 50); plan_add(0, 25); plan_add(1, 2); plan_add(0, 23);
    end
    plan_add(1, 50);
    plan_add(0, 20);
    run_plan();
    finish_plan("glitch");
  endtask

  initial begin
    test_reset();
    test_steady();
    test_random();
    test_overrun();
    test_back_to_back();
    test_enable_drop();
    test_timeout();
    test_glitch();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
